// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the IF/MEM memory-port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

  // Counter widths cover the full legal parameter ranges (1..15, 2..255).
  localparam int STARVE_W = 4;
  localparam int WAIT_W   = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data ports, with the fetch-starvation counter.
module mem_arb_pick
  import mips_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pick_en,
  input  logic if_req,
  input  logic dm_req,
  output logic req_any,
  output logic port
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic                if_forced;

  always_comb begin
    req_any   = if_req | dm_req;
    if_forced = if_req && (starve_cnt == STARVE_LIM);
    port      = (dm_req && !if_forced) ? PORT_DM : PORT_IF;
  end

  // Counts data wins taken while a fetch was waiting; a fetch win clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (pick_en && req_any) begin
      if (port == PORT_IF) begin
        starve_cnt <= '0;
      end else if (if_req && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// one outstanding transaction at a time, with timeout abort.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              err_timeout
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state, state_next;
  logic              winner;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pick_req, pick_port;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clock   (clock),
    .reset_n (reset_n),
    .pick_en (state == IDLE),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .req_any (pick_req),
    .port    (pick_port)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (mem_valid || wait_expired) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stalls are masked during reset so every output reads zero.
  always_comb begin
    mem_en   = (state == ISSUE);
    if_ack   = (state == ACK) && (winner == PORT_IF);
    dm_ack   = (state == ACK) && (winner == PORT_DM);
    if_stall = reset_n & if_req & ~if_ack;
    dm_stall = reset_n & dm_req & ~dm_ack;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      winner      <= PORT_IF;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wait_cnt    <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_req) begin
            winner <= pick_port;
            if (pick_port == PORT_DM) begin
              mem_addr  <= dm_addr;
              mem_we    <= dm_we;
              mem_wdata <= dm_wdata;
            end else begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (mem_valid) begin
            if (!mem_we) begin
              if (winner == PORT_IF) if_rdata <= mem_rdata;
              else                   dm_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_expired) begin
              err_timeout <= 1'b1;
              if (winner == PORT_IF) if_rdata <= '0;
              else                   dm_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of arbitration, latency, data return and timeout.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TO   = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic          if_stall;
  logic          dm_stall;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory responder: resp_delay cycles after mem_en it pulses mem_valid; 0 = never.
  int          pend = 0;
  int          resp_delay = 1;
  int          last_delay = 1;
  logic [31:0] resp_data = '0;
  logic [31:0] pend_data = '0;
  logic [31:0] last_data = '0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .if_stall(if_stall), .dm_stall(dm_stall), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
    cyc++;
    mem_valid = 1'b0;
    mem_rdata = $urandom;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_valid = 1'b1;
        mem_rdata = pend_data;
      end
    end
    if (mem_en === 1'b1) begin
      last_delay = resp_delay;
      last_data  = resp_data;
      pend       = resp_delay;
      pend_data  = resp_data;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall, err_timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall, err_timeout});
    end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    checks++;
    if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h required 0", mem_wdata); end
    checks++;
    if ({if_rdata, dm_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h required 0/0", if_rdata, dm_rdata);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_idle_en: got %b required 0", mem_en); end
  endtask

  task automatic test_single_load();
    int t0, en_cyc, ack_cyc, if_acks;
    logic [31:0] en_addr, ack_rd;
    logic en_we;
    en_cyc = -1; ack_cyc = -1; if_acks = 0;
    en_addr = '0; ack_rd = '0; en_we = 1'bx;
    resp_delay = 2; resp_data = 32'h12345678;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = '0;
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if_ack === 1'b1) if_acks++;
      if (mem_en === 1'b1 && en_cyc < 0) begin en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; end
      if (dm_ack === 1'b1 && ack_cyc < 0) begin ack_cyc = cyc; ack_rd = dm_rdata; dm_req = 1'b0; end
    end
    checks++;
    if (en_cyc - t0 !== 1) begin errors++; $display("FAIL load_en_latency: got %0d required 1", en_cyc - t0); end
    checks++;
    if (en_addr !== 32'h40 || en_we !== 1'b0) begin
      errors++; $display("FAIL load_mem_addr_we: got %h/%b required 00000040/0", en_addr, en_we);
    end
    checks++;
    if (ack_cyc - t0 !== 4) begin errors++; $display("FAIL load_ack_latency: got %0d required 4", ack_cyc - t0); end
    checks++;
    if (ack_rd !== 32'h12345678) begin errors++; $display("FAIL load_rdata: got %h required 12345678", ack_rd); end
    checks++;
    if (dm_rdata !== 32'h12345678) begin errors++; $display("FAIL load_rdata_hold: got %h required 12345678", dm_rdata); end
    checks++;
    if (if_acks !== 0) begin errors++; $display("FAIL load_if_ack: got %0d pulses required 0", if_acks); end
  endtask

  task automatic test_store();
    int t0, ack_cyc;
    logic [31:0] en_addr, en_wdata;
    logic en_we;
    ack_cyc = -1; en_addr = '0; en_wdata = '0; en_we = 1'b0;
    resp_delay = 3; resp_data = 32'hDEADBEEF;
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hCAFEF00D;
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_en === 1'b1) begin en_addr = mem_addr; en_wdata = mem_wdata; en_we = mem_we; end
      if (dm_ack === 1'b1 && ack_cyc < 0) begin ack_cyc = cyc; dm_req = 1'b0; dm_we = 1'b0; end
    end
    checks++;
    if ({en_we, en_addr, en_wdata} !== {1'b1, 32'h80, 32'hCAFEF00D}) begin
      errors++; $display("FAIL store_issue: got we=%b addr=%h wdata=%h required 1/00000080/cafef00d",
                         en_we, en_addr, en_wdata);
    end
    checks++;
    if (ack_cyc - t0 !== 5) begin errors++; $display("FAIL store_ack_latency: got %0d required 5", ack_cyc - t0); end
    checks++;
    if (dm_rdata !== 32'h12345678) begin errors++; $display("FAIL store_rdata_kept: got %h required 12345678", dm_rdata); end
  endtask

  task automatic test_starvation();
    int n, sc, stall_bad, got, want;
    n = 0; sc = 0; stall_bad = 0;
    resp_delay = 1; resp_data = 32'hA5A50001;
    tick();
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int k = 0; k < 120 && n < 10; k++) begin
      tick();
      if (if_stall !== !if_ack) stall_bad++;
      if (if_ack === 1'b1 || dm_ack === 1'b1) begin
        got  = (if_ack === 1'b1) ? 0 : 1;
        want = (sc == SMAX) ? 0 : 1;
        sc   = (want == 0) ? 0 : sc + 1;
        checks++;
        if (got !== want || (if_ack === 1'b1 && dm_ack === 1'b1)) begin
          errors++; $display("FAIL starve_grant_%0d: got port %0d required port %0d", n, got, want);
        end
        n++;
        if (n == 10) begin if_req = 1'b0; dm_req = 1'b0; end
      end
    end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL starve_grant_count: got %0d required 10", n); end
    checks++;
    if (stall_bad !== 0) begin errors++; $display("FAIL starve_if_stall: got %0d bad cycles required 0", stall_bad); end
    checks++;
    if (if_rdata !== 32'hA5A50001) begin errors++; $display("FAIL starve_if_rdata: got %h required a5a50001", if_rdata); end
  endtask

  task automatic test_timeout();
    int en_cyc, ack_cyc;
    logic [31:0] en_addr, ack_rd;
    logic ack_err;
    en_cyc = -1; ack_cyc = -1; en_addr = '0; ack_rd = 32'hFFFFFFFF; ack_err = 1'b0;
    resp_delay = 0;
    tick();
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (mem_en === 1'b1 && en_cyc < 0) begin en_cyc = cyc; en_addr = mem_addr; end
      if (if_ack === 1'b1 && ack_cyc < 0) begin
        ack_cyc = cyc; ack_rd = if_rdata; ack_err = err_timeout; if_req = 1'b0;
      end
    end
    checks++;
    if (en_addr !== 32'h100) begin errors++; $display("FAIL timeout_addr: got %h required 00000100", en_addr); end
    checks++;
    if (ack_cyc - (en_cyc + 1) !== TO) begin
      errors++; $display("FAIL timeout_latency: got %0d required %0d", ack_cyc - (en_cyc + 1), TO);
    end
    checks++;
    if (ack_rd !== 32'h0 || ack_err !== 1'b1) begin
      errors++; $display("FAIL timeout_result: got rdata=%h err=%b required 0/1", ack_rd, ack_err);
    end
    resp_delay = 1; resp_data = 32'h55AA55AA;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dm_ack === 1'b1) dm_req = 1'b0;
    end
    checks++;
    if (dm_rdata !== 32'h55AA55AA || err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got rdata=%h err=%b required 55aa55aa/1", dm_rdata, err_timeout);
    end
  endtask

  task automatic test_spurious_valid();
    int bad, t0, ack_cyc;
    logic [31:0] ack_rd;
    bad = 0; ack_cyc = -1; ack_rd = '0;
    tick();
    mem_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (if_ack === 1'b1 || dm_ack === 1'b1 || mem_en === 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL spur_idle_activity: got %0d events required 0", bad); end
    checks++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h55AA55AA) begin
      errors++; $display("FAIL spur_idle_rdata: got %h/%h required 00000000/55aa55aa", if_rdata, dm_rdata);
    end
    resp_delay = 2; resp_data = 32'h600D600D;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48;
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_en === 1'b1) begin mem_valid = 1'b1; mem_rdata = 32'hBAD1BAD1; end
      if (dm_ack === 1'b1 && ack_cyc < 0) begin
        ack_cyc = cyc; ack_rd = dm_rdata; dm_req = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'hBAD2BAD2;
      end
    end
    checks++;
    if (ack_cyc - t0 !== 4) begin errors++; $display("FAIL spur_issue_latency: got %0d required 4", ack_cyc - t0); end
    checks++;
    if (ack_rd !== 32'h600D600D || dm_rdata !== 32'h600D600D) begin
      errors++; $display("FAIL spur_rdata: got %h then %h required 600d600d", ack_rd, dm_rdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad, t0, ack_cyc;
    bad = 0; ack_cyc = -1;
    resp_delay = 5; resp_data = 32'h77777777;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4C;
    for (int k = 0; k < 6 && mem_en !== 1'b1; k++) tick();
    tick();
    tick();
    checks++;
    if (dm_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %b required 1", dm_stall); end
    #2;
    reset_n = 1'b0;
    dm_req = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall, err_timeout} !== 7'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_async_outputs: got ctrl=%b addr=%h rd=%h/%h required all 0",
                         {mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall, err_timeout},
                         mem_addr, if_rdata, dm_rdata);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (if_ack === 1'b1 || dm_ack === 1'b1 || mem_en === 1'b1) bad++;
    end
    checks++;
    if (bad !== 0 || dm_rdata !== 32'h0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_late_valid: got events=%0d rdata=%h err=%b required 0/0/0", bad, dm_rdata, err_timeout);
    end
    resp_delay = 1; resp_data = 32'h0BADF00D;
    tick();
    if_req = 1'b1; if_addr = 32'h1C0;
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (if_ack === 1'b1 && ack_cyc < 0) begin ack_cyc = cyc; if_req = 1'b0; end
    end
    checks++;
    if (ack_cyc - t0 !== 3 || if_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL rst_new_fetch: got latency=%0d rdata=%h required 3/0badf00d", ack_cyc - t0, if_rdata);
    end
  endtask

  task automatic test_random();
    logic p_if, p_dm, p_dm_we, m_active, m_prev_idle, m_win, m_we, m_to, m_err;
    logic was_ack, exp_en, exp_if_ack, exp_dm_ack, this_idle;
    logic [31:0] p_if_addr, p_dm_addr, p_dm_wdata, m_data, m_if_rd, m_dm_rd, exp_addr;
    int m_starve, m_ack_cyc;

    reset_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; pend = 0; resp_delay = 1;
    tick();
    tick();
    reset_n = 1'b1;
    p_if = 1'b0; p_dm = 1'b0; p_dm_we = 1'b0;
    p_if_addr = '0; p_dm_addr = '0; p_dm_wdata = '0;
    m_active = 1'b0; m_prev_idle = 1'b1; m_win = 1'b0; m_we = 1'b0; m_to = 1'b0; m_err = 1'b0;
    m_data = '0; m_if_rd = '0; m_dm_rd = '0; m_starve = 0; m_ack_cyc = 0;

    for (int k = 0; k < 1500; k++) begin
      tick();
      was_ack    = m_active && (cyc == m_ack_cyc);
      exp_if_ack = was_ack && (m_win == 1'b0);
      exp_dm_ack = was_ack && (m_win == 1'b1);
      if (was_ack) begin
        if (m_to) begin
          m_err = 1'b1;
          if (m_win) m_dm_rd = '0; else m_if_rd = '0;
        end else if (!m_we) begin
          if (m_win) m_dm_rd = m_data; else m_if_rd = m_data;
        end
      end
      exp_en = m_prev_idle && (p_if || p_dm);

      checks++;
      if (mem_en !== exp_en) begin errors++; $display("FAIL rand_mem_en cyc %0d: got %b required %b", cyc, mem_en, exp_en); end
      checks++;
      if ({if_ack, dm_ack} !== {exp_if_ack, exp_dm_ack}) begin
        errors++; $display("FAIL rand_acks cyc %0d: got %b%b required %b%b", cyc, if_ack, dm_ack, exp_if_ack, exp_dm_ack);
      end
      checks++;
      if (if_rdata !== m_if_rd || dm_rdata !== m_dm_rd) begin
        errors++; $display("FAIL rand_rdata cyc %0d: got %h/%h required %h/%h", cyc, if_rdata, dm_rdata, m_if_rd, m_dm_rd);
      end
      checks++;
      if (err_timeout !== m_err) begin errors++; $display("FAIL rand_err cyc %0d: got %b required %b", cyc, err_timeout, m_err); end
      checks++;
      if ({if_stall, dm_stall} !== {if_req && !exp_if_ack, dm_req && !exp_dm_ack}) begin
        errors++; $display("FAIL rand_stall cyc %0d: got %b%b required %b%b", cyc, if_stall, dm_stall,
                           if_req && !exp_if_ack, dm_req && !exp_dm_ack);
      end

      if (exp_en) begin
        m_win = (p_dm && !(p_if && m_starve == SMAX)) ? 1'b1 : 1'b0;
        if (!m_win)    m_starve = 0;
        else if (p_if) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        m_we     = m_win ? p_dm_we : 1'b0;
        exp_addr = m_win ? p_dm_addr : p_if_addr;
        checks++;
        if (mem_addr !== exp_addr || mem_we !== m_we || (m_we && mem_wdata !== p_dm_wdata)) begin
          errors++; $display("FAIL rand_issue cyc %0d: got addr=%h we=%b wd=%h required %h/%b/%h",
                             cyc, mem_addr, mem_we, mem_wdata, exp_addr, m_we, p_dm_wdata);
        end
        m_active  = 1'b1;
        m_to      = (last_delay == 0);
        m_data    = last_data;
        m_ack_cyc = m_to ? cyc + TO + 1 : cyc + last_delay + 1;
      end
      this_idle = !m_active;
      if (was_ack) m_active = 1'b0;

      if (exp_if_ack) if_req = 1'b0;
      if (exp_dm_ack) dm_req = 1'b0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom;
      end
      resp_delay = $urandom_range(0, TO);
      resp_data  = $urandom;

      p_if = if_req; p_dm = dm_req; p_dm_we = dm_we;
      p_if_addr = if_addr; p_dm_addr = dm_addr; p_dm_wdata = dm_wdata;
      m_prev_idle = this_idle;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store();
    test_starvation();
    test_timeout();
    test_spurious_valid();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the pipeline's instruction-fetch port (IF) and its data-memory port (MEM stage LW/SW).
- Arbitrates, sequences each access through a request/valid handshake with the memory, and returns per-port acknowledges.
- Returns stall qualifiers so the pipeline freezes IF or MEM while its access is pending.
- Detects memory timeouts.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data wins with a pending fetch before fetch is forced to win; range 1..15.
- TIMEOUT, 16, cycles in WAIT without mem_valid before abort; range 2..255.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high with stable if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid in the if_ack cycle, held until the next if_ack
- if_ack  out  1  one-cycle completion pulse
- dm_req  in  1  data request; held high with stable payload until dm_ack
- dm_we  in  1  1 = store (SW), 0 = load (LW)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid in the dm_ack cycle, held until the next dm_ack
- dm_ack  out  1  one-cycle completion pulse
- mem_en  out  1  one-cycle access strobe to backing memory
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  read data, sampled when mem_valid
- mem_valid  in  1  access complete (reads and writes)
- if_stall  out  1  if_req & ~if_ack
- dm_stall  out  1  dm_req & ~dm_ack
- err_timeout  out  1  sticky; set on any timeout abort, cleared only by reset

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0, including rdata registers, err_timeout and starve_cnt.
  - Any in-flight memory access is abandoned.
  - mem_valid arriving after reset is ignored while not in WAIT.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner, latch the winner id, addr, we and wdata into mem_* registers, go to ISSUE. IF requests are reads (we=0).
- Arbitration (IDLE only):
  - Only dm_req high: dm wins. Only if_req high: if wins.
  - Both high: dm wins unless starve_cnt==STARVE_MAX, in which case if wins.
- starve_cnt:
  - Increments (saturating) when dm wins while if_req is high.
  - Clears to 0 when if wins.
  - Unchanged otherwise.
- ISSUE: mem_en=1 for exactly this cycle; go to WAIT; clear wait counter.
- WAIT:
  - mem_valid=1: capture mem_rdata into the winner's rdata register (reads only; stores leave dm_rdata unchanged); go to ACK.
  - Otherwise increment the wait counter. When it reaches TIMEOUT: winner rdata <= 0, set err_timeout, go to ACK.
- ACK: the winner's ack=1 for one cycle; go to IDLE.
- A request still high in the IDLE cycle after its ACK is treated as a new request.
- Minimum latency: request seen in IDLE at cycle t -> mem_en at t+1 -> mem_valid earliest t+2 -> ack at t+3.
- Throughput: one access per 4 cycles minimum.
- mem_valid in IDLE, ISSUE or ACK is ignored and has no effect on state or data.
- Request changes outside IDLE do not alter the latched transaction. Dropping req before ack is a protocol violation: the access still completes and the ack is still issued.
- At most one transaction is outstanding at any time.

Decomposition:
- Package mips_mem_pkg:
  - State enum (IDLE, ISSUE, WAIT, ACK).
  - Port id constants PORT_IF=0, PORT_DM=1.
  - Default parameter values.
- Sub-module mem_arb_pick:
  - Combinational winner select.
  - Saturating starve_cnt register with its update rule.
  - Instantiated once in the top FSM.

Test Plan:
- Single load: dm_req, dm_we=0, dm_addr=0x40; memory returns 0x12345678 with mem_valid 2 cycles after mem_en -> mem_en at t+1, dm_ack at t+4, dm_rdata=0x12345678, if_ack never pulses.
- Store: dm_we=1, addr 0x80, wdata 0xCAFEF00D -> mem_we=1 and mem_wdata=0xCAFEF00D with mem_en; dm_ack after mem_valid; dm_rdata unchanged.
- Contention/starvation, STARVE_MAX=4: if_req and dm_req held high continuously (dm re-requests after each ack) -> grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF...; if_stall=1 until its ack.
- Timeout, TIMEOUT=16: fetch at 0x100, mem_valid withheld -> if_ack exactly 16 cycles after entering WAIT, if_rdata=0, err_timeout=1 and stays 1 through later successful accesses.
- Reset mid-WAIT: reset_n low during an outstanding load -> all outputs 0 immediately (async). Late mem_valid after reset_n rises produces no ack. A new request then completes normally.
- Spurious mem_valid pulsed in IDLE and in ISSUE -> no state change, no ack, rdata registers unchanged.
